fpadd_seq_ctrl: RTL and testbench

//  FSM sequencer for the iterative FP32 add/sub datapath. Accepts one op per valid/ready handshake.

---
 rtl/fpadd_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_fpadd_seq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_seq_ctrl.sv
// fpadd_seq_ctrl: sequencer for the iterative FP32 add/sub datapath.
// Walks one operation through CHECK, ALIGN, ADD, NORM, ROUND and RCHK, then
// holds the result in DONE until the consumer takes it. Only stage enables leave
// this block; operand data stays in the datapath.
// Build option: define FPADD_ALIGN_SKIP_EN so that an exponent gap of ALIGN_CAP or
// more issues a single align shift instead of ALIGN_CAP shifts. The datapath then
// flushes the smaller significand to sticky.
module fpadd_seq_ctrl #(
  parameter int EXP_W     = 8,
  parameter int MANT_W    = 23,
  parameter int ALIGN_CAP = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             op_sub,
  output logic             ld_ops,
  input  logic [1:0]       err,
  input  logic [EXP_W-1:0] exp_diff,
  output logic             align_shift,
  output logic             add_en,
  input  logic             carry_out,
  input  logic             sum_zero,
  input  logic             norm_msb,
  output logic             norm_rshift,
  output logic             norm_lshift,
  output logic             round_en,
  input  logic             round_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_err
);

  localparam int                NCNT_W   = $clog2(MANT_W + 2);
  localparam logic [NCNT_W-1:0] NORM_SAT = NCNT_W'(MANT_W + 1);
  localparam logic [EXP_W-1:0]  CAP      = EXP_W'(ALIGN_CAP);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_ALIGN, S_ADD, S_NORM,
    S_NRSH, S_ROUND, S_RCHK, S_RRSH, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               live_q;        // low on the first cycles after reset
  logic [EXP_W-1:0]   align_cnt_q;
  logic [EXP_W-1:0]   align_init;
  logic [NCNT_W-1:0]  norm_cnt_q;
  logic               norm_sat;
  logic [1:0]         res_err_q;
  logic               op_sub_q;
  logic               unused_sub;

  // The sequence is identical for add and subtract; the latched flag only
  // records the accepted operation.
  assign unused_sub = op_sub_q;
  assign norm_sat   = (norm_cnt_q == NORM_SAT);

  // Number of align shifts for the current exponent gap.
  always_comb begin
`ifdef FPADD_ALIGN_SKIP_EN
    align_init = (exp_diff >= CAP) ? EXP_W'(1) : exp_diff;
`else
    align_init = (exp_diff > CAP) ? CAP : exp_diff;
`endif
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every register in
    // the design updates from the same pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred when a case arm leaves the state unchanged.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (live_q && req_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (err != 2'd0)                  state_d = S_DONE;
        else if (align_init != '0)        state_d = S_ALIGN;
        else                              state_d = S_ADD;
      end
      S_ALIGN: if (align_cnt_q <= EXP_W'(1)) state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM: begin
        if (carry_out)                    state_d = S_NRSH;
        else if (sum_zero)                state_d = S_DONE;
        else if (norm_msb || norm_sat)    state_d = S_ROUND;
      end
      S_NRSH:  state_d = S_ROUND;
      S_ROUND: state_d = S_RCHK;
      // The post-round shift returns straight to DONE, so a second round
      // overflow is never sampled.
      S_RCHK:  state_d = round_ovf ? S_RRSH : S_DONE;
      S_RRSH:  state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. ld_ops and norm_lshift also look at the handshake and
  // the normalize inputs. The datapath must load in the accept cycle and shift
  // once per NORM cycle, and a state-only decode would add a cycle to each step.
  always_comb begin
    req_ready   = (state_q == S_IDLE) && live_q;
    ld_ops      = req_ready && req_valid;
    align_shift = (state_q == S_ALIGN);
    add_en      = (state_q == S_ADD);
    norm_rshift = (state_q == S_NRSH) || (state_q == S_RRSH);
    norm_lshift = (state_q == S_NORM) && !carry_out && !sum_zero &&
                  !norm_msb && !norm_sat;
    round_en    = (state_q == S_ROUND);
    res_valid   = (state_q == S_DONE);
    res_err     = res_err_q;
  end

  // Counters, result code and the accept-time latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q      <= 1'b0;
      align_cnt_q <= '0;
      norm_cnt_q  <= '0;
      res_err_q   <= 2'd0;
      op_sub_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (ld_ops) begin
            op_sub_q    <= op_sub;
            res_err_q   <= 2'd0;
            align_cnt_q <= '0;
            norm_cnt_q  <= '0;
          end
        end
        S_CHECK: begin
          if (err != 2'd0) res_err_q   <= err;
          else             align_cnt_q <= align_init;
        end
        S_ALIGN: align_cnt_q <= align_cnt_q - EXP_W'(1);
        S_NORM: begin
          if (norm_lshift)                 norm_cnt_q <= norm_cnt_q + NCNT_W'(1);
          else if (!carry_out && sum_zero) res_err_q  <= 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_seq_ctrl.sv
// tb_fpadd_seq_ctrl: directed bench for fpadd_seq_ctrl. A driver issues one op
// at a time and pushes the hand-computed expectation. A negedge monitor
// measures latency and pulse counts and checks the DONE hold behaviour.
module tb_fpadd_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, op_sub, ld_ops;
  logic [1:0] err;
  logic [7:0] exp_diff;
  logic       align_shift, add_en, carry_out, sum_zero, norm_msb;
  logic       norm_rshift, norm_lshift, round_en, round_ovf;
  logic       res_valid, res_ready;
  logic [1:0] res_err;

  always #5 clk = ~clk;

  fpadd_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op_sub(op_sub), .ld_ops(ld_ops), .err(err), .exp_diff(exp_diff),
    .align_shift(align_shift), .add_en(add_en), .carry_out(carry_out),
    .sum_zero(sum_zero), .norm_msb(norm_msb), .norm_rshift(norm_rshift),
    .norm_lshift(norm_lshift), .round_en(round_en), .round_ovf(round_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_err(res_err)
  );

  typedef struct {
    int         id;
    logic [1:0] err;
    logic [7:0] ed;
    logic       carry, zero, rovf;
    int         lsh, hold;
    int         lat;
    logic [1:0] rerr;
    int         n_al, n_add, n_lsh, n_rsh, n_rnd;
  } vec_t;

  vec_t exp_q[$];
  vec_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Datapath stub: the sum becomes normalized after cur_lsh left shifts.
  int   cur_lsh = 0;
  int   lsh_seen = 0;
  assign norm_msb = (lsh_seen >= cur_lsh);

  always @(posedge clk) begin
    if (ld_ops)           lsh_seen <= 0;
    else if (norm_lshift) lsh_seen <= lsh_seen + 1;
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic vec_t mk(input int id, input logic [1:0] e, input logic [7:0] ed,
                              input logic c, input logic z, input int lsh,
                              input logic rovf, input int hold, input int lat,
                              input logic [1:0] rerr, input int n_al, input int n_add,
                              input int n_lsh, input int n_rsh, input int n_rnd);
    vec_t v;
    v.id = id; v.err = e; v.ed = ed; v.carry = c; v.zero = z; v.lsh = lsh;
    v.rovf = rovf; v.hold = hold; v.lat = lat; v.rerr = rerr; v.n_al = n_al;
    v.n_add = n_add; v.n_lsh = n_lsh; v.n_rsh = n_rsh; v.n_rnd = n_rnd;
    return v;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  int   lat, na, nadd, nl, nr, nrnd;
  logic busy = 1'b0, in_done = 1'b0, ready_chk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0; in_done = 1'b0; ready_chk = 1'b0;
      exp_q.delete();
    end else begin
      if (ready_chk) begin
        check("req_ready_after_handoff", int'(req_ready), 1);
        check("res_valid_after_handoff", int'(res_valid), 0);
        ready_chk = 1'b0;
      end
      if (ld_ops) begin
        busy = 1'b1; lat = 0; na = 0; nadd = 0; nl = 0; nr = 0; nrnd = 0;
      end else if (busy) begin
        lat++;
        na   += int'(align_shift);
        nadd += int'(add_en);
        nl   += int'(norm_lshift);
        nr   += int'(norm_rshift);
        nrnd += int'(round_en);
        if (res_valid) begin
          busy = 1'b0;
          check("result_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check($sformatf("op%0d_latency", cur.id), lat, cur.lat);
            check($sformatf("op%0d_align_shifts", cur.id), na, cur.n_al);
            check($sformatf("op%0d_add_pulses", cur.id), nadd, cur.n_add);
            check($sformatf("op%0d_lshifts", cur.id), nl, cur.n_lsh);
            check($sformatf("op%0d_rshifts", cur.id), nr, cur.n_rsh);
            check($sformatf("op%0d_round_pulses", cur.id), nrnd, cur.n_rnd);
            in_done = 1'b1;
          end
        end
      end
      if (in_done && res_valid) begin
        check($sformatf("op%0d_res_err", cur.id), int'(res_err), int'(cur.rerr));
        check($sformatf("op%0d_req_ready_in_done", cur.id), int'(req_ready), 0);
        if (res_ready) begin
          in_done = 1'b0;
          ready_chk = 1'b1;
        end
      end
    end
  end

  // Driver: inputs change 1 time unit after the rising edge.
  task automatic run_op(input vec_t v);
    int guard;
    guard = 0;
    while (!req_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    check($sformatf("op%0d_req_ready_wait", v.id), int'(req_ready), 1);
    err = v.err; exp_diff = v.ed; carry_out = v.carry; sum_zero = v.zero;
    round_ovf = v.rovf; cur_lsh = v.lsh; op_sub = v.id[0];
    req_valid = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!res_valid && guard < 200) begin @(posedge clk); #1; guard++; end
    check($sformatf("op%0d_res_valid_timeout", v.id), int'(res_valid), 1);
    repeat (v.hold) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic int out_bus();
    return int'({req_ready, ld_ops, align_shift, add_en, norm_rshift,
                 norm_lshift, round_en, res_valid, res_err});
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; op_sub = 1'b0; err = 2'd0; exp_diff = 8'd0;
    carry_out = 1'b0; sum_zero = 1'b0; round_ovf = 1'b0; res_ready = 1'b0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("por_outputs_zero", out_bus(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("por_req_ready", int'(req_ready), 1);
    @(posedge clk); #1;

    // Fields: id err ed carry zero lsh rovf hold | lat rerr al add lsh rsh rnd
    run_op(mk(1, 2'd2, 8'd0,   0, 0, 0, 0, 0,   2, 2'd2, 0, 0, 0, 0, 0));
    run_op(mk(2, 2'd0, 8'd0,   0, 0, 0, 0, 0,   6, 2'd0, 0, 1, 0, 0, 1));
    run_op(mk(3, 2'd0, 8'd5,   0, 0, 0, 0, 0,  11, 2'd0, 5, 1, 0, 0, 1));
`ifdef FPADD_ALIGN_SKIP_EN
    run_op(mk(4, 2'd0, 8'd200, 0, 0, 0, 0, 0,   7, 2'd0, 1, 1, 0, 0, 1));
    run_op(mk(5, 2'd0, 8'd26,  0, 0, 0, 0, 0,   7, 2'd0, 1, 1, 0, 0, 1));
`else
    run_op(mk(4, 2'd0, 8'd200, 0, 0, 0, 0, 0,  32, 2'd0, 26, 1, 0, 0, 1));
    run_op(mk(5, 2'd0, 8'd26,  0, 0, 0, 0, 0,  32, 2'd0, 26, 1, 0, 0, 1));
`endif
    run_op(mk(6,  2'd0, 8'd25, 0, 0, 0, 0, 0,  31, 2'd0, 25, 1, 0, 0, 1));
    run_op(mk(7,  2'd0, 8'd0,  0, 0, 3, 0, 0,   9, 2'd0, 0, 1, 3, 0, 1));
    run_op(mk(8,  2'd0, 8'd0,  1, 0, 5, 0, 0,   7, 2'd0, 0, 1, 0, 1, 1));
    run_op(mk(9,  2'd0, 8'd0,  1, 0, 0, 1, 0,   8, 2'd0, 0, 1, 0, 2, 1));
    run_op(mk(10, 2'd0, 8'd0,  0, 1, 0, 0, 0,   4, 2'd1, 0, 1, 0, 0, 0));
    run_op(mk(11, 2'd3, 8'd9,  0, 0, 0, 0, 4,   2, 2'd3, 0, 0, 0, 0, 0));
    run_op(mk(12, 2'd1, 8'd0,  0, 0, 0, 0, 0,   2, 2'd1, 0, 0, 0, 0, 0));
    run_op(mk(13, 2'd0, 8'd0,  0, 0, 30, 0, 0, 30, 2'd0, 0, 1, 24, 0, 1));
    run_op(mk(14, 2'd0, 8'd0,  0, 0, 0, 1, 0,   7, 2'd0, 0, 1, 0, 1, 1));
    run_op(mk(15, 2'd0, 8'd1,  0, 0, 2, 1, 2,  10, 2'd0, 1, 1, 2, 1, 1));

    // Reset in the middle of ALIGN drops the op.
    err = 2'd0; exp_diff = 8'd200; carry_out = 1'b0; sum_zero = 1'b0;
    round_ovf = 1'b0; cur_lsh = 0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mid_align_shift_active", int'(align_shift), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_outputs_zero", out_bus(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_req_ready", int'(req_ready), 1);
    check("mid_reset_no_result", int'(res_valid), 0);
    @(posedge clk); #1;

    // The controller still works after the aborted op.
    run_op(mk(16, 2'd0, 8'd2, 0, 0, 1, 0, 0, 9, 2'd0, 2, 1, 1, 0, 1));

    repeat (2) @(posedge clk);
    check("no_pending_results", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
